// File: rtl/vpc_fetch_ctrl.sv
// VPC fetch sequencer: arbitrates for the MCU bus, drives the VPC address,
// hands fetched words to decode and applies branch/jump redirects to the VPC.
module vpc_fetch_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_fetch_en,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  output logic              o_bus_req,
  input  logic              i_bus_gnt,
  output logic              o_addr_oe,
  output logic              o_addr_valid,
  output logic              o_vpc_lock,
  output logic              o_vpc_set,
  output logic [ADDR_W-1:0] o_vpc_set_addr,
  input  logic              i_mcu_ack,
  input  logic [DATA_W-1:0] i_mcu_data,
  output logic [DATA_W-1:0] o_instr,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic              o_fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_HOLD, S_ADVANCE, S_REDIRECT, S_FAULT
  } state_t;

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              fault_q, fault_d;
  logic              timeout_hit;

  // True on the ADDR cycle that would bring the wait count up to TIMEOUT.
  assign timeout_hit = ({1'b0, cnt_q} + 9'd1) >= TO_LIM;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      raddr_q <= '0;
      instr_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      raddr_q <= raddr_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    raddr_d = i_redirect_valid ? i_redirect_addr : raddr_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (i_redirect_valid)  state_d = S_REDIRECT;
        else if (i_fetch_en)   state_d = S_REQ;
      end
      S_REQ: begin
        if (i_redirect_valid)  state_d = S_REDIRECT;
        else if (i_bus_gnt)    state_d = S_ADDR;
      end
      S_ADDR: begin
        if (i_redirect_valid) pend_d = 1'b1;
        if (i_mcu_ack) begin
          instr_d = i_mcu_data;
          cnt_d   = '0;
          // A redirect seen during this wait (even on the ack cycle) kills the word.
          state_d = (pend_q || i_redirect_valid) ? S_REDIRECT : S_HOLD;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (i_redirect_valid)   state_d = S_REDIRECT;
        else if (i_instr_ready) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (i_redirect_valid)  state_d = S_REDIRECT;
        else if (i_fetch_en)   state_d = S_REQ;
        else                   state_d = S_IDLE;
      end
      S_REDIRECT: begin
        pend_d = 1'b0;
        if (i_redirect_valid)  state_d = S_REDIRECT;
        else if (i_fetch_en)   state_d = S_REQ;
        else                   state_d = S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    fault_d = fault_q || (state_d == S_FAULT);
  end

  always_comb begin
    o_bus_req     = 1'b0;
    o_addr_oe     = 1'b0;
    o_addr_valid  = 1'b0;
    o_vpc_lock    = 1'b1;
    o_vpc_set     = 1'b0;
    o_instr_valid = 1'b0;
    case (state_q)
      S_REQ: o_bus_req = 1'b1;
      S_ADDR: begin
        o_bus_req    = 1'b1;
        o_addr_oe    = 1'b1;
        o_addr_valid = 1'b1;
      end
      S_HOLD:     o_instr_valid = 1'b1;
      S_ADVANCE:  o_vpc_lock    = 1'b0;
      S_REDIRECT: begin
        o_vpc_lock = 1'b0;
        o_vpc_set  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_vpc_set_addr = raddr_q;
  assign o_instr        = instr_q;
  assign o_fault        = fault_q;

endmodule

// File: tb/tb_vpc_fetch_ctrl.sv
// Self-checking bench for vpc_fetch_ctrl: directed scenarios followed by random
// traffic, compared each cycle against a transaction-level model of the fetch loop.
module tb_vpc_fetch_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          fen = 1'b0, rv = 1'b0, gnt = 1'b0, ack = 1'b0, rdy = 1'b0;
  logic [AW-1:0] ra = '0;
  logic [DW-1:0] dat = '0;
  logic          bus_req, addr_oe, addr_valid, vpc_lock, vpc_set, instr_valid, fault;
  logic [AW-1:0] set_addr;
  logic [DW-1:0] instr;

  int total = 0;
  int bad = 0;

  vpc_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_fetch_en(fen), .i_redirect_valid(rv), .i_redirect_addr(ra),
    .o_bus_req(bus_req), .i_bus_gnt(gnt),
    .o_addr_oe(addr_oe), .o_addr_valid(addr_valid),
    .o_vpc_lock(vpc_lock), .o_vpc_set(vpc_set), .o_vpc_set_addr(set_addr),
    .i_mcu_ack(ack), .i_mcu_data(dat),
    .o_instr(instr), .o_instr_valid(instr_valid), .i_instr_ready(rdy),
    .o_fault(fault)
  );

  always #5 clk = ~clk;

  // Model: where the fetch loop is, how long the MCU has been waited on,
  // whether a redirect is owed, and the last redirect target / fetched word.
  localparam int P_IDLE = 0, P_ASK = 1, P_WAIT = 2, P_OFFER = 3, P_STEP = 4, P_JUMP = 5, P_DEAD = 6;
  int            m_ph;
  int            m_waited;
  bit            m_owed;
  logic [AW-1:0] m_target;
  logic [DW-1:0] m_word;

  task automatic model_reset();
    m_ph = P_IDLE; m_waited = 0; m_owed = 0; m_target = '0; m_word = '0;
  endtask

  task automatic model_clk();
    int nx;
    nx = m_ph;
    if (m_ph == P_WAIT) begin
      m_waited = m_waited + 1;
      if (rv) m_owed = 1;
      if (ack) begin
        m_word = dat;
        m_waited = 0;
        nx = m_owed ? P_JUMP : P_OFFER;
      end else if (m_waited >= TO) begin
        nx = P_DEAD;
      end
    end else if (m_ph == P_DEAD) begin
      nx = P_DEAD;
    end else if (rv && m_ph != P_OFFER) begin
      nx = P_JUMP;
    end else if (m_ph == P_OFFER) begin
      nx = rv ? P_JUMP : (rdy ? P_STEP : P_OFFER);
    end else if (m_ph == P_ASK) begin
      nx = gnt ? P_WAIT : P_ASK;
    end else begin
      nx = fen ? P_ASK : P_IDLE;
    end
    if (m_ph == P_JUMP) m_owed = 0;
    if (rv) m_target = ra;
    m_ph = nx;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bus_req",     32'(bus_req),     32'(m_ph == P_ASK || m_ph == P_WAIT));
    chk("addr_oe",     32'(addr_oe),     32'(m_ph == P_WAIT));
    chk("addr_valid",  32'(addr_valid),  32'(m_ph == P_WAIT));
    chk("vpc_lock",    32'(vpc_lock),    32'(m_ph != P_STEP && m_ph != P_JUMP));
    chk("vpc_set",     32'(vpc_set),     32'(m_ph == P_JUMP));
    chk("instr_valid", 32'(instr_valid), 32'(m_ph == P_OFFER));
    chk("fault",       32'(fault),       32'(m_ph == P_DEAD));
    chk("set_addr",    set_addr,         m_target);
    chk("instr",       instr,            m_word);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clk();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    n_rst = 1'b1;
  endtask

  task automatic quiet();
    fen = 0; rv = 0; gnt = 0; ack = 0; rdy = 0; ra = '0; dat = '0;
  endtask

  initial begin
    int nvalid, nunlock, last, nset, naddr;
    model_reset();

    // Reset values
    quiet();
    do_reset();
    chk("rst_lock", 32'(vpc_lock), 32'd1);
    chk("rst_instr", instr, 32'd0);

    // Back-to-back fetches at best-case cadence
    fen = 1; gnt = 1; ack = 1; rdy = 1; dat = 32'hDEADBEEF;
    tick();
    nvalid = 0; nunlock = 0; last = -1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (!vpc_lock) nunlock++;
      if (instr_valid) begin
        chk("cad_instr", instr, 32'hDEADBEEF);
        if (last >= 0) chk("cad_gap", 32'(i - last), 32'd4);
        last = i;
        nvalid++;
      end
    end
    chk("cad_nvalid", 32'(nvalid), 32'd8);
    chk("cad_nunlock", 32'(nunlock), 32'd8);

    // Redirect during ADDR, ack arrives 3 cycles later
    quiet(); do_reset();
    fen = 1; gnt = 1;
    tick(); tick();
    chk("r1_in_addr", 32'(addr_valid), 32'd1);
    rv = 1; ra = 32'h40; tick();
    rv = 0; tick(); tick();
    ack = 1; dat = 32'h12345678; tick();
    chk("r1_set", 32'(vpc_set), 32'd1);
    chk("r1_set_addr", set_addr, 32'h40);
    chk("r1_no_valid", 32'(instr_valid), 32'd0);
    ack = 0; tick();
    chk("r1_resume_req", 32'(bus_req), 32'd1);
    chk("r1_set_off", 32'(vpc_set), 32'd0);

    // Two redirects in one ADDR wait: last one wins, single REDIRECT
    quiet(); do_reset();
    fen = 1; gnt = 1;
    tick(); tick();
    nset = 0;
    rv = 1; ra = 32'h10; tick(); if (vpc_set) nset++;
    ra = 32'h20; tick(); if (vpc_set) nset++;
    rv = 0; ack = 1; tick(); if (vpc_set) nset++;
    chk("r2_set_addr", set_addr, 32'h20);
    fen = 0; ack = 0; tick(); if (vpc_set) nset++;
    tick(); if (vpc_set) nset++;
    chk("r2_nset", 32'(nset), 32'd1);

    // Bus timeout into sticky FAULT
    quiet(); do_reset();
    fen = 1; gnt = 1;
    tick();
    naddr = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (addr_valid) naddr++;
    end
    chk("to_naddr", 32'(naddr), 32'(TO));
    for (int i = 0; i < 5; i++) begin
      ack = 1'($urandom_range(0, 1)); rdy = 1; tick();
      chk("to_fault", 32'(fault), 32'd1);
      chk("to_oe", 32'(addr_oe), 32'd0);
      chk("to_req", 32'(bus_req), 32'd0);
      chk("to_lock", 32'(vpc_lock), 32'd1);
    end
    quiet(); do_reset();
    chk("to_cleared", 32'(fault), 32'd0);

    // Decode stalls in HOLD
    fen = 1; gnt = 1; ack = 1; dat = 32'hCAFE0001;
    tick(); tick(); tick();
    ack = 0; dat = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_instr", instr, 32'hCAFE0001);
      chk("hold_lock", 32'(vpc_lock), 32'd1);
      chk("hold_req", 32'(bus_req), 32'd0);
    end
    rdy = 1; tick();
    chk("hold_adv", 32'(vpc_lock), 32'd0);
    rdy = 0; fen = 0; tick();

    // Asynchronous reset in the middle of an ADDR cycle
    fen = 1; gnt = 1;
    tick(); tick();
    chk("ar_oe_before", 32'(addr_oe), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("ar_oe_drop", 32'(addr_oe), 32'd0);
    chk("ar_req_drop", 32'(bus_req), 32'd0);
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    fen = 0;
    tick();
    chk("ar_idle", 32'(bus_req), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      fen = ($urandom_range(0, 7) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      ra  = $urandom;
      gnt = ($urandom_range(0, 1) == 1);
      ack = ($urandom_range(0, 3) != 0);
      dat = $urandom;
      rdy = ($urandom_range(0, 2) != 0);
      tick();
      if (m_ph == P_DEAD || $urandom_range(0, 299) == 0) begin
        quiet();
        tick();
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
